// File: rtl/pcre_engine_pkg.sv
// Shared helpers for the parametrised PCRE chain engine: class-width derivation,
// CLASS_SEL slice extraction and parameter legality.
package pcre_engine_pkg;

    localparam int unsigned MAX_STATES = 64;
    localparam int unsigned MAX_SEL_W  = 64 * 16;
    localparam int unsigned GAP_LIMIT  = 1023;

    function automatic int unsigned cls_width(input int unsigned n_classes);
        return (n_classes > 1) ? $clog2(n_classes) : 1;
    endfunction

    function automatic int unsigned class_sel(input logic [MAX_SEL_W-1:0] sel,
                                              input int unsigned i,
                                              input int unsigned w);
        logic [MAX_SEL_W-1:0] sh;
        logic [15:0]          mask;
        sh   = sel >> (i * w);
        mask = 16'((32'd1 << w) - 32'd1);
        return {16'd0, sh[15:0] & mask};
    endfunction

    function automatic bit params_ok(input int unsigned n_states,
                                     input int unsigned gap_pos,
                                     input int unsigned gap_max);
        return (n_states >= 1) && (n_states <= MAX_STATES) &&
               (gap_pos <= n_states) && (gap_max <= GAP_LIMIT);
    endfunction

endpackage

// File: rtl/pcre_gap_counter.sv
// Bounded any-byte gap tracker: live while fewer than GAP_MAX gap bytes have
// been consumed since the most recent entry.
module pcre_gap_counter #(
    parameter int unsigned GAP_MAX = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic enter,
    output logic live
);

    localparam int unsigned GC_W = $clog2(GAP_MAX + 1) + 1;

    logic [GC_W-1:0] gc_q, gc_d;
    logic            live_q, live_d;

    // A fresh entry restarts the count, which keeps {0,MAX} exact.
    always_comb begin
        gc_d   = gc_q;
        live_d = live_q;
        if (en) begin
            if (enter) begin
                gc_d   = GC_W'(1);
                live_d = (GAP_MAX >= 1);
            end else if (live_q) begin
                gc_d   = gc_q + GC_W'(1);
                live_d = ((32'(gc_q) + 32'd1) <= GAP_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gc_q   <= '0;
            live_q <= 1'b0;
        end else begin
            gc_q   <= gc_d;
            live_q <= live_d;
        end
    end

    assign live = live_q;

endmodule

// File: rtl/pcre_chain_engine.sv
// One-hot NFA for a single linear PCRE chain with loops, skips, anchoring and one
// bounded gap. Match-offset capture is built only with PCRE_ENGINE_OFFSET_EN.
module pcre_chain_engine
    import pcre_engine_pkg::*;
#(
    parameter int unsigned N_STATES  = 16,
    parameter int unsigned N_CLASSES = 128,
    parameter logic [N_STATES*cls_width(N_CLASSES)-1:0] CLASS_SEL = '0,
    parameter logic [N_STATES-1:0] LOOP_MASK = '0,
    parameter logic [N_STATES-1:0] SKIP_MASK = '0,
    parameter bit          ANCHORED  = 1'b0,
    parameter int unsigned GAP_POS   = N_STATES,
    parameter int unsigned GAP_MAX   = 0,
    parameter int unsigned OFF_W     = 16
) (
    input  logic                 clk,
    input  logic                 sod,
    input  logic                 en,
    input  logic [N_CLASSES-1:0] cls,
    output logic                 busy,
    output logic                 out,
    output logic [OFF_W-1:0]     match_off
);

    localparam int unsigned          CLS_W   = cls_width(N_CLASSES);
    localparam logic [MAX_SEL_W-1:0] SEL_EXT = MAX_SEL_W'(CLASS_SEL);

    if (!params_ok(N_STATES, GAP_POS, GAP_MAX)) begin : g_bad_params
        $error("pcre_chain_engine: GAP_POS/GAP_MAX/N_STATES out of range");
    end

    logic [N_STATES-1:0] s_q, s_d, hit;
    logic                first_q, first_d;
    logic                out_q, out_d;
    logic                gap_enter, glive;

    for (genvar gi = 0; gi < N_STATES; gi++) begin : g_hit
        localparam int unsigned CI = class_sel(SEL_EXT, gi, CLS_W);
        assign hit[gi] = cls[CI];
    end

    // The running entry term walks the chain; the gap state sees entry OR glive.
    always_comb begin
        logic ent;
        logic feed;
        ent       = ANCHORED ? first_q : 1'b1;
        gap_enter = 1'b0;
        s_d       = s_q;
        for (int unsigned i = 0; i < N_STATES; i++) begin
            feed = ent;
            if (i == GAP_POS) begin
                gap_enter = ent;
                feed      = ent | glive;
            end
            if (en)
                s_d[i] = hit[i] & (feed | (LOOP_MASK[i] & s_q[i]));
            ent = s_q[i] | (SKIP_MASK[i] & feed);
        end
        first_d = en ? 1'b0 : first_q;
        out_d   = out_q | s_q[N_STATES-1];
    end

    pcre_gap_counter #(
        .GAP_MAX (GAP_MAX)
    ) u_gap (
        .clk   (clk),
        .rst   (sod),
        .en    (en),
        .enter (gap_enter),
        .live  (glive)
    );

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            s_q     <= '0;
            first_q <= 1'b1;
            out_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            first_q <= first_d;
            out_q   <= out_d;
        end
    end

`ifdef PCRE_ENGINE_OFFSET_EN
    logic [OFF_W-1:0] bc_q, bc_d, off_q, off_d;

    always_comb begin
        bc_d  = bc_q;
        off_d = off_q;
        if (en) begin
            if (bc_q != '1)
                bc_d = bc_q + OFF_W'(1);
            if (s_d[N_STATES-1] && !s_q[N_STATES-1] && !out_q)
                off_d = bc_q;
        end
    end

    always_ff @(posedge clk or posedge sod) begin
        if (sod) begin
            bc_q  <= '0;
            off_q <= '0;
        end else begin
            bc_q  <= bc_d;
            off_q <= off_d;
        end
    end

    assign match_off = off_q;
`else
    assign match_off = '0;
`endif

    assign busy = (|s_q) | glive;
    assign out  = out_q;

endmodule

// File: tb/tb_pcre_chain_engine.sv
// Self-checking bench: four engine configurations share one byte stream and are
// compared against a string-level regex model of "ab.{0,3}cd" and "ab*cd".
module tb_pcre_chain_engine;

    localparam int unsigned NS = 4;
    localparam int unsigned NC = 8;
    localparam logic [11:0] SEL = {3'd4, 3'd3, 3'd2, 3'd1};

    logic        clk = 1'b0;
    logic        sod;
    logic        en;
    logic [7:0]  cls;

    logic        busy_g, out_g, busy_a, out_a, busy_l, out_l, busy_s, out_s;
    logic [15:0] off_g, off_a, off_l;
    logic [2:0]  off_s;

    always #5 clk = ~clk;

    pcre_chain_engine #(
        .N_STATES(NS), .N_CLASSES(NC), .CLASS_SEL(SEL), .LOOP_MASK(4'b0000),
        .SKIP_MASK(4'b0000), .ANCHORED(1'b0), .GAP_POS(2), .GAP_MAX(3), .OFF_W(16)
    ) u_gap (
        .clk(clk), .sod(sod), .en(en), .cls(cls),
        .busy(busy_g), .out(out_g), .match_off(off_g)
    );

    pcre_chain_engine #(
        .N_STATES(NS), .N_CLASSES(NC), .CLASS_SEL(SEL), .LOOP_MASK(4'b0000),
        .SKIP_MASK(4'b0000), .ANCHORED(1'b1), .GAP_POS(2), .GAP_MAX(3), .OFF_W(16)
    ) u_anc (
        .clk(clk), .sod(sod), .en(en), .cls(cls),
        .busy(busy_a), .out(out_a), .match_off(off_a)
    );

    pcre_chain_engine #(
        .N_STATES(NS), .N_CLASSES(NC), .CLASS_SEL(SEL), .LOOP_MASK(4'b0010),
        .SKIP_MASK(4'b0010), .ANCHORED(1'b0), .GAP_POS(4), .GAP_MAX(0), .OFF_W(16)
    ) u_loop (
        .clk(clk), .sod(sod), .en(en), .cls(cls),
        .busy(busy_l), .out(out_l), .match_off(off_l)
    );

    pcre_chain_engine #(
        .N_STATES(NS), .N_CLASSES(NC), .CLASS_SEL(SEL), .LOOP_MASK(4'b0010),
        .SKIP_MASK(4'b0010), .ANCHORED(1'b0), .GAP_POS(4), .GAP_MAX(0), .OFF_W(3)
    ) u_sat (
        .clk(clk), .sod(sod), .en(en), .cls(cls),
        .busy(busy_s), .out(out_s), .match_off(off_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: bytes accepted since sod, last-state-live, sticky out, first match end.
    byte txt[$];
    bit  ms[4];
    bit  mo[4];
    int  moff[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] cls_of(input byte ch);
        logic [7:0] v;
        v = 8'($urandom) & 8'hE1;
        case (ch)
            "a": v[1] = 1'b1;
            "b": v[2] = 1'b1;
            "c": v[3] = 1'b1;
            "d": v[4] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // Does a match of configuration c end exactly at byte k of txt?
    function automatic bit ends_at(input int c, input int k);
        if (k < 2 || txt[k] != "d" || txt[k-1] != "c")
            return 1'b0;
        if (c >= 2) begin
            for (int j = k - 2; j >= 0; j--) begin
                if (txt[j] == "a") return 1'b1;
                if (txt[j] != "b") return 1'b0;
            end
            return 1'b0;
        end
        for (int p = 0; p <= k - 3; p++)
            if ((c == 0 || p == 0) && txt[p] == "a" && txt[p+1] == "b" && (k - 3 - p) <= 3)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_off(input int c);
`ifdef PCRE_ENGINE_OFFSET_EN
        if (moff[c] < 0) return 32'd0;
        if (c == 3 && moff[c] > 7) return 32'd7;
        return 32'(moff[c]);
`else
        return 32'(c - c);
`endif
    endfunction

    task automatic check_all();
        chk("out_gap",  {31'd0, out_g}, {31'd0, mo[0]});
        chk("out_anc",  {31'd0, out_a}, {31'd0, mo[1]});
        chk("out_loop", {31'd0, out_l}, {31'd0, mo[2]});
        chk("out_sat",  {31'd0, out_s}, {31'd0, mo[3]});
        chk("off_gap",  {16'd0, off_g}, exp_off(0));
        chk("off_anc",  {16'd0, off_a}, exp_off(1));
        chk("off_loop", {16'd0, off_l}, exp_off(2));
        chk("off_sat",  {29'd0, off_s}, exp_off(3));
    endtask

    task automatic model_clear();
        txt.delete();
        for (int c = 0; c < 4; c++) begin
            ms[c]   = 1'b0;
            mo[c]   = 1'b0;
            moff[c] = -1;
        end
    endtask

    // Called just after a negedge; holds sod across one rising edge.
    task automatic do_sod(input bit with_en);
        sod = 1'b1;
        en  = with_en;
        cls = cls_of("c");
        @(posedge clk);
        @(negedge clk);
        sod = 1'b0;
        en  = 1'b0;
        model_clear();
        chk("rst_busy", {28'd0, busy_g, busy_a, busy_l, busy_s}, 32'd0);
        check_all();
    endtask

    task automatic step(input bit e, input byte ch);
        en  = e;
        cls = e ? cls_of(ch) : 8'($urandom);
        @(posedge clk);
        for (int c = 0; c < 4; c++)
            mo[c] = mo[c] | ms[c];
        if (e) begin
            txt.push_back(ch);
            for (int c = 0; c < 4; c++) begin
                ms[c] = ends_at(c, txt.size() - 1);
                if (ms[c] && moff[c] < 0)
                    moff[c] = txt.size() - 1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic run_str(input string s);
        for (int i = 0; i < s.len(); i++)
            step(1'b1, s[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string alpha;
        alpha = "abcdxab1";
        sod = 1'b1;
        en  = 1'b0;
        cls = '0;
        model_clear();
        @(negedge clk);
        do_sod(1'b0);

        // Offset-at-match and gap length limits
        run_str("xxabcd"); step(1'b0, "x");
        chk("t1_out", {31'd0, out_g}, 32'd1);
`ifdef PCRE_ENGINE_OFFSET_EN
        chk("t1_off", {16'd0, off_g}, 32'd5);
`endif
        do_sod(1'b0); run_str("ab123cd"); step(1'b0, "x");
        chk("t2_gap3", {31'd0, out_g}, 32'd1);
        do_sod(1'b0); run_str("ab1234cd"); step(1'b0, "x"); step(1'b0, "x");
        chk("t2_gap4", {31'd0, out_g}, 32'd0);

        // Gap re-entry
        do_sod(1'b0); run_str("ab1ab9999cd"); step(1'b0, "x");
        chk("t3_reenter_nomatch", {31'd0, out_g}, 32'd0);
        do_sod(1'b0); run_str("ab1ab12cd"); step(1'b0, "x");
        chk("t3_reenter_match", {31'd0, out_g}, 32'd1);
`ifdef PCRE_ENGINE_OFFSET_EN
        chk("t3_off", {16'd0, off_g}, 32'd8);
`endif

        // Anchoring
        do_sod(1'b0); run_str("xabcd"); step(1'b0, "x");
        chk("t4_anc_late", {31'd0, out_a}, 32'd0);
        do_sod(1'b0); run_str("abcd"); step(1'b0, "x");
        chk("t4_anc_first", {31'd0, out_a}, 32'd1);
`ifdef PCRE_ENGINE_OFFSET_EN
        chk("t4_off", {16'd0, off_a}, 32'd3);
`endif

        // sod mid-stream, with a concurrent byte that must be dropped
        do_sod(1'b0); run_str("ab");
        chk("t5_busy_live", {31'd0, busy_g}, 32'd1);
        do_sod(1'b1); run_str("cd"); step(1'b0, "x");
        chk("t5_cut", {31'd0, out_g}, 32'd0);

        // Loop/skip chain with an en-low hold mid-stream
        do_sod(1'b0); run_str("acd"); step(1'b0, "x");
        chk("t6_skip", {31'd0, out_l}, 32'd1);
        do_sod(1'b0); run_str("abb");
        for (int i = 0; i < 5; i++) step(1'b0, "z");
        run_str("bcd"); step(1'b0, "x");
        chk("t6_loop", {31'd0, out_l}, 32'd1);
`ifdef PCRE_ENGINE_OFFSET_EN
        chk("t6_off", {16'd0, off_l}, 32'd5);
`endif

        // Everything drains after a run of non-matching bytes
        do_sod(1'b0); run_str("abxxxxx");
        chk("drain_busy", {28'd0, busy_g, busy_a, busy_l, busy_s}, 32'd0);

        // Offset saturation on the narrow-offset instance
        do_sod(1'b0); run_str("xxxxxxxxxxacd"); step(1'b0, "x");
        chk("sat_out", {31'd0, out_s}, 32'd1);
`ifdef PCRE_ENGINE_OFFSET_EN
        chk("sat_off", {29'd0, off_s}, 32'd7);
`endif

        // Randomized streams
        for (int it = 0; it < 40; it++) begin
            int len;
            do_sod($urandom_range(0, 1) == 1);
            len = $urandom_range(10, 50);
            for (int i = 0; i < len; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 4)
                    do_sod($urandom_range(0, 1) == 1);
                else
                    step(r < 85, alpha[$urandom_range(0, alpha.len() - 1)]);
            end
            step(1'b0, "x");
            step(1'b0, "x");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
